rtc_hms_core: RTL and testbench
===============================

# rtc_hms_core

- Free-running time-of-day counter: hours, minutes and seconds, advanced by an internal seconds prescaler.
- Presents hours in 24 h or 12 h format, selectable at run time, with the AM/PM display code.
- Sits between the system clock and the seven-segment display driver.
- Accepts time loads from the button/set logic through a request/acknowledge handshake.

## Interface
- `TICK_DIV`, default 50_000_000: `clk` cycles per second; legal range ≥ 2.
- `FIELD_W`, default 7: width of every time field and display code; legal range ≥ 6.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode12` in 1: 1 = 12 h display, 0 = 24 h display; display only, never alters the count.
- `set_req` in 1: load request; the set fields below are sampled while it is high.
- `set_hours` in FIELD_W: load value for hours, 0–23.
- `set_minutes` in FIELD_W: load value for minutes, 0–59.
- `set_seconds` in FIELD_W: load value for seconds, 0–59.
- `set_ack` out 1: one-cycle pulse; load accepted.
- `set_err` out 1: one-cycle pulse; load rejected, time unchanged.
- `hours_disp` out FIELD_W: displayed hours; 0–23, or 1–12 when `mode12` = 1.
- `minutes` out FIELD_W: current minutes.
- `seconds` out FIELD_W: current seconds.
- `day_night` out FIELD_W: AM/PM display code; 10 = AM, 11 = PM, 15 = blank (24 h mode).
- `sec_tick` out 1: one-cycle pulse on every seconds advance.
- `day_wrap` out 1: one-cycle pulse on the 23:59:59 → 00:00:00 transition.

## Operation
- Internal 24 h registers `hr` (0–23), `mn` (0–59) and `sc` (0–59), plus prescaler `pre` (0..TICK_DIV-1).
- Prescaler: `pre` increments each cycle. At TICK_DIV-1 it returns to 0 and generates a tick.
- Tick, carry chain:
  - `sc` +1 normally; at 59 it wraps to 0 and carries into `mn`.
  - `mn` at 59 wraps to 0 and carries into `hr`.
  - `hr` at 23 wraps to 0.
- Handshake, two states:
  - IDLE: a rising `set_req` (low in the previous cycle) is evaluated on that edge. If all fields are in range, the fields load, `pre` clears to 0 and `set_ack` pulses. Otherwise `set_err` pulses and nothing changes. Then go to WAIT.
  - WAIT: stays until `set_req` = 0, then returns to IDLE. Holding `set_req` high gives exactly one load.
- Load and tick on the same edge: the load wins. The tick is discarded, and `sec_tick` and `day_wrap` stay 0.
- Display conversion is combinational from the registers:
  - `mode12` = 1: `hours_disp` = 12 when `hr` = 0; `hr` − 12 when `hr` > 12; otherwise `hr`.
  - `mode12` = 1: `day_night` = 10 when `hr` < 12, else 11.
  - `mode12` = 0: `hours_disp` = `hr`, `day_night` = 15.
- Width rules: all fields are zero-extended to FIELD_W. The prescaler width is $clog2(TICK_DIV). Range checks are unsigned.

## Timing
- Reset values:
  - `hr`, `mn`, `sc`, `pre` = 0; handshake state IDLE.
  - `set_ack`, `set_err`, `sec_tick`, `day_wrap` = 0.
  - Display shows `hours_disp` = 12, `day_night` = 10 in 12 h mode; 0 and 15 in 24 h mode.
- The first tick occurs TICK_DIV cycles after reset deasserts.
- After a load, the next tick occurs TICK_DIV cycles after the load edge.
- `sec_tick`, `day_wrap` and the time registers update on the same edge. `day_wrap` coincides with its `sec_tick`.
- `set_ack` / `set_err` are high for the cycle after the sampling edge. Load latency is 1 cycle.
- `mode12` changes take effect combinationally. There is no glitch filtering.
- Reset asserted mid-handshake: the handshake returns to IDLE immediately. If `set_req` is still high at release, it is not treated as a new request until it drops and rises again.

## Configuration
- `RTC_ALARM_EN` defined adds these ports:
  - `alarm_wr` in 1
  - `alarm_hours` in FIELD_W
  - `alarm_minutes` in FIELD_W
  - `alarm_on` in 1
  - `alarm_ring` out 1
- Alarm behaviour:
  - `alarm_wr` loads the alarm hour and minute registers; the values are held unchecked. Reset value is 00:00.
  - `alarm_ring` asserts on the tick that makes `hr:mn:sc` equal to alarm:00 while `alarm_on` = 1.
  - `alarm_ring` clears when `alarm_on` = 0 or after 60 ticks.
  - Reset value of `alarm_ring` is 0.
- Without `RTC_ALARM_EN` these ports and registers do not exist. Core behaviour is identical.

## Test plan
- Reset with TICK_DIV=4, `mode12`=1 -> `hours_disp`=12 and `day_night`=10 during reset; first `sec_tick` 4 cycles after release; `seconds`=1.
- Load 23:59:58 with TICK_DIV=4 -> `set_ack` pulses next cycle; after 2 ticks, `day_wrap`=1 with `sec_tick`; time 00:00:00.
- Load 13:05:00 -> 12 h mode gives `hours_disp`=1, `day_night`=11; 24 h mode gives 13 and 15. Load 12:00:00 in 12 h mode -> 12 and 11.
- Load 24:00:00, then 10:60:00 -> `set_err` pulses each time; time unchanged; no `set_ack`.
- `set_req` held 10 cycles, rising on the same edge as a tick -> exactly one `set_ack`; loaded value kept; no `sec_tick` that cycle.
- `RTC_ALARM_EN`: alarm 07:30, `alarm_on`=1, load 07:29:59 -> `alarm_ring`=1 at the next tick; 0 after 60 ticks, or immediately when `alarm_on`=0.

Source files
------------

// File: rtl/rtc_hms_core.sv
`default_nettype none
// ============================================================================
// Module   : rtc_hms_core
// Function : HH:MM:SS time-of-day counter with prescaler, 12/24 h display,
//            and request/acknowledge time load. `RTC_ALARM_EN adds an alarm.
// Revision : 1.0 - initial release
// ============================================================================
module rtc_hms_core #(
    parameter int TICK_DIV = 50_000_000,
    parameter int FIELD_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode12,
    input  logic               set_req,
    input  logic [FIELD_W-1:0] set_hours,
    input  logic [FIELD_W-1:0] set_minutes,
    input  logic [FIELD_W-1:0] set_seconds,
    output logic               set_ack,
    output logic               set_err,
    output logic [FIELD_W-1:0] hours_disp,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] seconds,
    output logic [FIELD_W-1:0] day_night,
    output logic               sec_tick,
    output logic               day_wrap
`ifdef RTC_ALARM_EN
    ,
    input  logic               alarm_wr,
    input  logic [FIELD_W-1:0] alarm_hours,
    input  logic [FIELD_W-1:0] alarm_minutes,
    input  logic               alarm_on,
    output logic               alarm_ring
`endif
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [PRE_W-1:0]   C_PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [FIELD_W-1:0] C_HR_MAX  = FIELD_W'(23);
    localparam logic [FIELD_W-1:0] C_MS_MAX  = FIELD_W'(59);
    localparam logic [FIELD_W-1:0] C_12      = FIELD_W'(12);
    localparam logic [FIELD_W-1:0] C_AM      = FIELD_W'(10);
    localparam logic [FIELD_W-1:0] C_PM      = FIELD_W'(11);
    localparam logic [FIELD_W-1:0] C_BLANK   = FIELD_W'(15);

    logic [0:0]         state_q, state_d;
    logic               req_prev_q;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [FIELD_W-1:0] hr_q, hr_d, mn_q, mn_d, sc_q, sc_d;
    logic               set_ack_q, set_ack_d, set_err_q, set_err_d;
    logic               sec_tick_q, sec_tick_d, day_wrap_q, day_wrap_d;

    logic w_tick, w_req_rise, w_load_evt, w_fields_ok, w_load_ok;

    assign w_tick      = (pre_q == C_PRE_MAX);
    assign w_req_rise  = set_req & ~req_prev_q;
    assign w_load_evt  = (state_q == ST_IDLE) & w_req_rise;
    assign w_fields_ok = (set_hours <= C_HR_MAX) & (set_minutes <= C_MS_MAX) &
                         (set_seconds <= C_MS_MAX);
    assign w_load_ok   = w_load_evt & w_fields_ok;

    // req_prev_q resets high so a request still held across reset is not a new one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            req_prev_q <= set_req;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_req_rise) state_d = ST_WAIT;
            ST_WAIT: if (!set_req)   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_d      = w_tick ? '0 : pre_q + PRE_W'(1);
        hr_d       = hr_q;
        mn_d       = mn_q;
        sc_d       = sc_q;
        set_ack_d  = 1'b0;
        set_err_d  = 1'b0;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        if (w_load_ok) begin
            // A load overrides any tick landing on the same edge
            hr_d      = set_hours;
            mn_d      = set_minutes;
            sc_d      = set_seconds;
            pre_d     = '0;
            set_ack_d = 1'b1;
        end else begin
            set_err_d = w_load_evt;
            if (w_tick) begin
                sec_tick_d = 1'b1;
                if (sc_q == C_MS_MAX) begin
                    sc_d = '0;
                    if (mn_q == C_MS_MAX) begin
                        mn_d = '0;
                        if (hr_q == C_HR_MAX) begin
                            hr_d       = '0;
                            day_wrap_d = 1'b1;
                        end else begin
                            hr_d = hr_q + FIELD_W'(1);
                        end
                    end else begin
                        mn_d = mn_q + FIELD_W'(1);
                    end
                end else begin
                    sc_d = sc_q + FIELD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q      <= '0;
            hr_q       <= '0;
            mn_q       <= '0;
            sc_q       <= '0;
            set_ack_q  <= 1'b0;
            set_err_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            hr_q       <= hr_d;
            mn_q       <= mn_d;
            sc_q       <= sc_d;
            set_ack_q  <= set_ack_d;
            set_err_q  <= set_err_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    always_comb begin
        hours_disp = hr_q;
        day_night  = C_BLANK;
        if (mode12) begin
            if (hr_q == '0) begin
                hours_disp = C_12;
            end else if (hr_q > C_12) begin
                hours_disp = hr_q - C_12;
            end
            day_night = (hr_q < C_12) ? C_AM : C_PM;
        end
    end

    assign set_ack  = set_ack_q;
    assign set_err  = set_err_q;
    assign minutes  = mn_q;
    assign seconds  = sc_q;
    assign sec_tick = sec_tick_q;
    assign day_wrap = day_wrap_q;

`ifdef RTC_ALARM_EN
    logic [FIELD_W-1:0] alarm_hr_q, alarm_hr_d, alarm_mn_q, alarm_mn_d;
    logic               ring_q, ring_d;
    logic [5:0]         ring_cnt_q, ring_cnt_d;
    logic               w_alarm_hit;

    assign w_alarm_hit = sec_tick_d & (hr_d == alarm_hr_q) & (mn_d == alarm_mn_q) &
                         (sc_d == '0);

    // Ring lasts for the matching tick plus 59 more, i.e. cleared on the 60th
    always_comb begin
        alarm_hr_d = alarm_wr ? alarm_hours   : alarm_hr_q;
        alarm_mn_d = alarm_wr ? alarm_minutes : alarm_mn_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (!alarm_on) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
        end else if (w_alarm_hit) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end else if (ring_q && sec_tick_d) begin
            if (ring_cnt_q == 6'd59) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else begin
                ring_cnt_d = ring_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hr_q <= '0;
            alarm_mn_q <= '0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            alarm_hr_q <= alarm_hr_d;
            alarm_mn_q <= alarm_mn_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign alarm_ring = ring_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_hms_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_hms_core
// Function : Scoreboard bench for rtc_hms_core against a seconds-of-day model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_hms_core;
    localparam int TD = 4;
    localparam int FW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode12 = 1'b1;
    logic          set_req = 1'b0;
    logic [FW-1:0] set_hours = '0, set_minutes = '0, set_seconds = '0;
    logic          set_ack, set_err, sec_tick, day_wrap;
    logic [FW-1:0] hours_disp, minutes, seconds, day_night;

    rtc_hms_core #(.TICK_DIV(TD), .FIELD_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .mode12(mode12), .set_req(set_req),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .set_ack(set_ack), .set_err(set_err), .hours_disp(hours_disp),
        .minutes(minutes), .seconds(seconds), .day_night(day_night),
        .sec_tick(sec_tick), .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit ack;
        bit err;
        bit tick;
        bit wrap;
        int tod;
    } ev_t;

    ev_t q[$];
    int  m_tod = 0;
    int  m_cnt = 0;
    bit  m_prev = 1'b1;
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic void disp(input int tod, input bit m12, output int h, output int dn);
        int h24;
        h24 = tod / 3600;
        if (!m12) begin
            h  = h24;
            dn = 15;
        end else begin
            h  = (h24 % 12 == 0) ? 12 : h24 % 12;
            dn = (h24 < 12) ? 10 : 11;
        end
    endfunction

    // Reference model: time as seconds since midnight, prescaler as cycle count
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_tod  = 0;
                m_cnt  = 0;
                m_prev = 1'b1;
                q.delete();
            end else begin
                ev_t e;
                bit  tick, rise;
                tick   = (m_cnt == TD - 1);
                m_cnt  = (m_cnt + 1) % TD;
                rise   = set_req && !m_prev;
                m_prev = set_req;
                e      = '0;
                if (rise && set_hours < 24 && set_minutes < 60 && set_seconds < 60) begin
                    m_tod = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
                    m_cnt = 0;
                    e.ack = 1'b1;
                end else begin
                    e.err = rise;
                    if (tick) begin
                        m_tod  = (m_tod + 1) % 86400;
                        e.tick = 1'b1;
                        e.wrap = (m_tod == 0);
                    end
                end
                e.tod = m_tod;
                if (e.ack || e.err || e.tick) q.push_back(e);
            end
        end
    end

    // Monitor: each cycle either an expected event is due, or all strobes must be idle
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (q.size() == 0) begin
                    chk("idle_strobes", {set_ack, set_err, sec_tick, day_wrap}, 0);
                end else begin
                    ev_t e;
                    int  h, dn;
                    e = q.pop_front();
                    disp(e.tod, mode12, h, dn);
                    chk("strobes", {set_ack, set_err, sec_tick, day_wrap},
                        {e.ack, e.err, e.tick, e.wrap});
                    chk("hours_disp", hours_disp, h);
                    chk("minutes", minutes, (e.tod / 60) % 60);
                    chk("seconds", seconds, e.tod % 60);
                    chk("day_night", day_night, dn);
                end
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int h, input int m, input int s, input int hold,
                        output bit ack, output bit err);
        set_hours   = FW'(h);
        set_minutes = FW'(m);
        set_seconds = FW'(s);
        set_req     = 1'b1;
        cyc(1);
        ack = set_ack;
        err = set_err;
        cyc(hold);
        set_req = 1'b0;
        cyc(1);
    endtask

    initial begin
        bit ack, err;
        int guard;

        rst_n  = 1'b0;
        mode12 = 1'b1;
        cyc(3);
        chk("rst_hours12", hours_disp, 12);
        chk("rst_dn12", day_night, 10);
        mode12 = 1'b0;
        #1;
        chk("rst_hours24", hours_disp, 0);
        chk("rst_dn24", day_night, 15);
        chk("rst_strobes", {set_ack, set_err, sec_tick, day_wrap}, 0);
        mode12 = 1'b1;
        rst_n  = 1'b1;
        for (int i = 1; i <= TD; i++) begin
            cyc(1);
            chk("first_tick", sec_tick, (i == TD) ? 1 : 0);
        end
        chk("first_tick_sec", seconds, 1);

        load(23, 59, 58, 1, ack, err);
        chk("load_ack", ack, 1);
        cyc(2 * TD + 2);

        load(13, 5, 0, 1, ack, err);
        mode12 = 1'b1;
        #1;
        chk("pm_hours12", hours_disp, 1);
        chk("pm_dn12", day_night, 11);
        mode12 = 1'b0;
        #1;
        chk("pm_hours24", hours_disp, 13);
        chk("pm_dn24", day_night, 15);
        load(12, 0, 0, 1, ack, err);
        mode12 = 1'b1;
        #1;
        chk("noon_hours12", hours_disp, 12);
        chk("noon_dn12", day_night, 11);

        load(24, 0, 0, 2, ack, err);
        chk("bad_hour_err", {ack, err}, 1);
        load(10, 60, 0, 2, ack, err);
        chk("bad_min_err", {ack, err}, 1);

        guard = 0;
        while (m_cnt != TD - 1 && guard < 4 * TD) begin
            cyc(1);
            guard++;
        end
        chk("align_guard", (guard < 4 * TD) ? 1 : 0, 1);
        set_hours = 7'd6; set_minutes = 7'd7; set_seconds = 7'd8;
        set_req = 1'b1;
        cyc(1);
        chk("tick_edge_ack", set_ack, 1);
        chk("tick_edge_tick", sec_tick, 0);
        cyc(9);
        set_req = 1'b0;
        cyc(2);

        set_hours = 7'd1; set_minutes = 7'd2; set_seconds = 7'd3;
        set_req = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        chk("rst_mid_hs_sec", seconds, 0);
        set_req = 1'b0;
        cyc(2);

        for (int n = 0; n < 40; n++) begin
            int gap;
            mode12 = 1'($urandom);
            load($urandom_range(0, 25), $urandom_range(0, 61), $urandom_range(0, 61),
                 $urandom_range(1, 5), ack, err);
            gap = $urandom_range(0, 12);
            for (int k = 0; k < gap; k++) begin
                mode12 = 1'($urandom);
                cyc(1);
            end
        end
        load(23, 59, 50, 1, ack, err);
        cyc(12 * TD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
